// File: rtl/perf_monitor_unit.sv
// rtl/perf_monitor_unit.sv - cycle/commit/event performance counters with halt freeze, watchdog and read port
module perf_monitor_unit #(
  parameter int NUM_EVT    = 4,
  parameter int CNT_W      = 32,
  parameter int SAT        = 1,
  parameter int WDOG_LIMIT = 1024,
  parameter int SEL_W      = $clog2(NUM_EVT + 2)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clear,
  input  logic                 commit,
  input  logic                 halt,
  input  logic [NUM_EVT-1:0]   evt,
  input  logic [SEL_W-1:0]     rd_sel,
  output logic [CNT_W-1:0]     rd_data,
  output logic                 frozen,
  output logic                 wdog_trip,
  output logic [NUM_EVT+1:0]   overflow
);

  localparam int NCNT = NUM_EVT + 2;
  localparam int WD_W = (WDOG_LIMIT > 0) ? $clog2(WDOG_LIMIT + 1) : 1;
  localparam logic [WD_W-1:0]  WD_LIM  = WD_W'(WDOG_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FROZEN, S_TRIP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NCNT];
  logic [CNT_W-1:0]   cnt_d [NCNT];
  logic [NCNT-1:0]    ovf_q, ovf_d;
  logic [WD_W-1:0]    idle_q, idle_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic               frozen_q, frozen_d;
  logic               trip_q, trip_d;
  logic [NCNT-1:0]    inc;
  logic               wd_hit;

  // Counter index 0 = cycles, 1 = commits, 2+i = event channel i
  assign inc = {evt, commit, 1'b1};

  // Next-state: counting, watchdog, freeze/trip decisions, clear, and read mux on post-update values
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    idle_d    = idle_q;
    wd_hit    = 1'b0;
    rd_data_d = '0;
    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_RUN;
      end
      S_RUN: begin
        if (en) begin
          for (int i = 0; i < NCNT; i++) begin
            if (inc[i]) begin
              if (cnt_q[i] == CNT_MAX) begin
                ovf_d[i] = 1'b1;
                cnt_d[i] = (SAT != 0) ? CNT_MAX : '0;
              end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
              end
            end
          end
          if (commit) begin
            idle_d = '0;
          end else begin
            idle_d = idle_q + 1'b1;
            wd_hit = (WDOG_LIMIT != 0) && (idle_d == WD_LIM);
          end
          // A halt in the expiry cycle takes precedence over the watchdog
          if (halt)        state_d = S_FROZEN;
          else if (wd_hit) state_d = S_TRIP;
        end
      end
      default: ;
    endcase
    if (clear) begin
      state_d = S_IDLE;
      for (int i = 0; i < NCNT; i++) cnt_d[i] = '0;
      ovf_d  = '0;
      idle_d = '0;
    end
    frozen_d = (state_d == S_FROZEN);
    trip_d   = (state_d == S_TRIP);
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel == SEL_W'(i)) rd_data_d = cnt_d[i];
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      ovf_q     <= '0;
      idle_q    <= '0;
      rd_data_q <= '0;
      frozen_q  <= 1'b0;
      trip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      idle_q    <= idle_d;
      rd_data_q <= rd_data_d;
      frozen_q  <= frozen_d;
      trip_q    <= trip_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign frozen    = frozen_q;
  assign wdog_trip = trip_q;
  assign overflow  = ovf_q;

endmodule

// File: doc/perf_monitor_unit.md
Name: perf_monitor_unit

Overview:
- Synthesizable, parametrised performance monitor for the pipelined core; successor to bench-only commit/cache counting.
- Counts cycles, committed instructions and NUM_EVT event channels, e.g. I-cache req/hit and D-cache req/hit.
- Freezes on halt, trips a no-commit watchdog, and exposes any counter through a registered read port for debug/MMIO.
- Instantiated beside the core; inputs come from the writeback/halt stage and the caches.

Parameters:
- NUM_EVT, 4, number of event channels (1..14).
- CNT_W, 32, width of every counter (8..64).
- SAT, 1, 1 = counters saturate at max; 0 = counters wrap to 0.
- WDOG_LIMIT, 1024, consecutive no-commit counting cycles before trip; 0 disables the watchdog.
- SEL_W, $clog2(NUM_EVT+2), derived; read-select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  counting enable.
- clear  in  1  synchronous clear of counters, flags and state.
- commit  in  1  one instruction retires this cycle (RegWrite|MemWrite|Halt at writeback).
- halt  in  1  halt instruction retires this cycle.
- evt  in  NUM_EVT  per-channel event pulse, one count per cycle high.
- rd_sel  in  SEL_W  counter select: 0 = cycles, 1 = instructions, 2+i = evt[i].
- rd_data  out  CNT_W  registered read data.
- frozen  out  1  halt seen; counters stopped.
- wdog_trip  out  1  watchdog expired; counters stopped.
- overflow  out  NUM_EVT+2  sticky per-counter overflow, same indexing as rd_sel.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst. No asynchronous logic.
- Priority each edge: rst > clear > state/count logic.
- rst: every counter, overflow, rd_data, frozen and wdog_trip go to 0; state = IDLE.
- clear has the same effect as rst; it is the only exit from FROZEN/TRIP other than rst.
- FSM states: IDLE, RUN, FROZEN, TRIP.
- IDLE -> RUN when en = 1. The transition cycle does not count.
- In RUN, a counting cycle is any cycle with en = 1.
  - en = 0 pauses everything: counters and watchdog hold, state stays RUN.
- In a counting cycle:
  - cycle_cnt += 1.
  - inst_cnt += commit.
  - evt_cnt[i] += evt[i].
  - All updates land in the same edge.
- RUN -> FROZEN on a counting cycle with halt = 1. That cycle's increments are applied. frozen = 1 from the next cycle.
- Watchdog idle count:
  - Resets to 0 on any counting cycle with commit = 1.
  - Increments on counting cycles with commit = 0.
  - On reaching WDOG_LIMIT: RUN -> TRIP and wdog_trip = 1 next cycle. That cycle's increments are applied.
- halt and watchdog expiry in the same cycle: FROZEN wins and wdog_trip stays 0.
- FROZEN/TRIP: all counters hold; commit, evt and halt are ignored; rd_sel reads still work.
- halt, commit and evt are ignored in IDLE.
- Overflow:
  - Triggered by an increment while a counter equals 2^CNT_W-1.
  - SAT = 1: counter holds at max. SAT = 0: counter wraps to 0.
  - In both modes the matching overflow bit sets and stays set until rst/clear.
- Read port:
  - rd_data is registered with 1-cycle latency: it shows the value selected by rd_sel at edge N, sampled after edge N's update.
  - rd_sel > NUM_EVT+1 returns 0.
  - Reading has no side effects.

Test Plan:
- Basic count: rst 2 cycles, en = 1, 10 counting cycles, commit on 6, evt[0] on 3, halt on cycle 10.
  - Expect cycles = 10, insts = 6, evt0 = 3; frozen = 1 after cycle 10.
  - Further pulses leave all counts unchanged.
- Pause: en high 5 counting cycles, low 4 cycles, high 5 counting cycles, commit every cycle.
  - Expect cycles = 10, insts = 10.
- Watchdog: WDOG_LIMIT = 8, en = 1, commit = 0.
  - wdog_trip = 1 after counting cycle 8; cycle_cnt = 8.
  - Same run with commit pulsed every 7th cycle: never trips.
- Saturate/wrap: CNT_W = 8, evt[1] held high 260 counting cycles.
  - SAT = 1: evt1 = 255, overflow[3] = 1.
  - SAT = 0: evt1 = 4, overflow[3] = 1.
- Read latency and priority:
  - rd_sel 0..NUM_EVT+1 sweep: each value appears one cycle later; rd_sel = 15 returns 0.
  - clear and halt in the same cycle: everything 0, state IDLE.
  - rst mid-RUN: all outputs 0 the next cycle.
